// File: rtl/apb_mig_bridge.sv
// apb_mig_bridge: single-clock APB slave to MIG user-port bridge.
// Posted-write command queue, blocking reads, optional read timeout.
//
// Parameters: ADDR_W, DATA_W, MIG_ADDR_W, CMD_DEPTH, TIMEOUT.
// APB side : pclk_i, preset_ni (sync, active-low), psel_i, penable_i,
//            pwrite_i, paddr_i, pwdata_i, pstrb_i -> pready_o,
//            pslverr_o, prdata_o.
// MIG side : mig_ready_i, mig_valid_i, mig_data_i -> mig_en_o,
//            mig_w_en_o, mig_addr_o, mig_data_o, mig_strb_o.
// Optional : define APB_MIG_TIMEOUT_EN for read timeout and late-data
//            discard; default build waits for read data forever.
module apb_mig_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MIG_ADDR_W = 27,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_W-1:0]     paddr_i,
  input  logic [DATA_W-1:0]     pwdata_i,
  input  logic [DATA_W/8-1:0]   pstrb_i,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [DATA_W-1:0]     prdata_o,
  input  logic                  mig_ready_i,
  output logic                  mig_en_o,
  output logic                  mig_w_en_o,
  output logic [MIG_ADDR_W-1:0] mig_addr_o,
  output logic [DATA_W-1:0]     mig_data_o,
  output logic [DATA_W/8-1:0]   mig_strb_o,
  input  logic                  mig_valid_i,
  input  logic [DATA_W-1:0]     mig_data_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HI     = OFF_W + MIG_ADDR_W;

  if ((DATA_W % 8) != 0 || DATA_W < 16) begin : g_bad_data
    $error("DATA_W must be a multiple of 8 and at least 16");
  end
  if (HI > ADDR_W) begin : g_bad_addr
    $error("MIG_ADDR_W plus byte offset exceeds ADDR_W");
  end
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("CMD_DEPTH must be a power of two, at least 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  if (HI < ADDR_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^paddr_i[ADDR_W-1:HI];
  end

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_t;

  logic access;
  logic misaligned;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign access     = psel_i & penable_i;
  assign misaligned = |paddr_i[OFF_W-1:0];

  logic                  q_w [CMD_DEPTH];
  logic [MIG_ADDR_W-1:0] q_a [CMD_DEPTH];
  logic [DATA_W-1:0]     q_d [CMD_DEPTH];
  logic [STRB_W-1:0]     q_s [CMD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  assign full  = (count == CNT_W'(CMD_DEPTH));
  assign empty = (count == '0);
  assign pop   = ~empty & mig_ready_i;

  // full is taken from the registered count, so a push is refused
  // even when a pop frees a slot in the same cycle.
  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        q_w[i] <= 1'b0;
        q_a[i] <= '0;
        q_d[i] <= '0;
        q_s[i] <= '0;
      end
    end else begin
      if (push) begin
        q_w[wr_ptr] <= pwrite_i;
        q_a[wr_ptr] <= paddr_i[OFF_W +: MIG_ADDR_W];
        q_d[wr_ptr] <= pwdata_i;
        q_s[wr_ptr] <= pwrite_i ? pstrb_i : '0;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   rdata_d;
  logic                err_q;
  logic                err_d;
  logic                drop_q;
  logic                rdy;
  logic                slverr;
  logic [DATA_W-1:0]   rdata_out;

`ifdef APB_MIG_TIMEOUT_EN
  localparam int TC_W = $clog2(TIMEOUT);

  logic            drop_d;
  logic [TC_W-1:0] tcnt_q;
  logic [TC_W-1:0] tcnt_d;

  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      drop_q <= 1'b0;
      tcnt_q <= '0;
    end else begin
      drop_q <= drop_d;
      tcnt_q <= tcnt_d;
    end
  end
`else
  assign drop_q = 1'b0;
`endif

  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    rdy       = 1'b0;
    slverr    = 1'b0;
    rdata_out = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef APB_MIG_TIMEOUT_EN
    drop_d    = drop_q;
    tcnt_d    = tcnt_q;
    // Late data for a timed-out read is swallowed here.
    if (drop_q && mig_valid_i) begin
      drop_d = 1'b0;
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            rdy    = 1'b1;
            slverr = 1'b1;
          end else if (pwrite_i) begin
            if (!full) begin
              push = 1'b1;
              rdy  = 1'b1;
            end
          end else if (!full && !drop_q) begin
            push    = 1'b1;
            state_d = RD_WAIT;
`ifdef APB_MIG_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
      end
      RD_WAIT: begin
        if (mig_valid_i) begin
          rdata_d = mig_data_i;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef APB_MIG_TIMEOUT_EN
        else if (tcnt_q == TC_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          drop_d  = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
`endif
      end
      RESP: begin
        rdy       = 1'b1;
        slverr    = err_q;
        rdata_out = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held.
  assign pready_o   = preset_ni & rdy;
  assign pslverr_o  = preset_ni & slverr;
  assign prdata_o   = preset_ni ? rdata_out : '0;
  assign mig_en_o   = preset_ni & pop;
  assign mig_w_en_o = preset_ni & pop & q_w[rd_ptr];
  assign mig_addr_o = preset_ni ? q_a[rd_ptr] : '0;
  assign mig_data_o = preset_ni ? q_d[rd_ptr] : '0;
  assign mig_strb_o = preset_ni ? q_s[rd_ptr] : '0;

endmodule

// File: tb/tb_apb_mig_bridge.sv
// tb_apb_mig_bridge: directed bench for apb_mig_bridge with a
// transaction-level model checked every cycle.
module tb_apb_mig_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 27;
  localparam int DEPTH = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready;
  logic          pslverr;
  logic [DW-1:0] prdata;
  logic          mig_ready;
  logic          mig_en;
  logic          mig_w_en;
  logic [MW-1:0] mig_addr;
  logic [DW-1:0] mig_wdata;
  logic [3:0]    mig_strb;
  logic          mig_valid;
  logic [DW-1:0] mig_rdata;

  apb_mig_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .MIG_ADDR_W(MW),
    .CMD_DEPTH(DEPTH), .TIMEOUT(TO)
  ) dut (
    .pclk_i(clk), .preset_ni(rst_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready), .pslverr_o(pslverr), .prdata_o(prdata),
    .mig_ready_i(mig_ready), .mig_en_o(mig_en),
    .mig_w_en_o(mig_w_en), .mig_addr_o(mig_addr),
    .mig_data_o(mig_wdata), .mig_strb_o(mig_strb),
    .mig_valid_i(mig_valid), .mig_data_i(mig_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          w;
    logic [MW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    s;
  } cmd_t;

  typedef enum {PH_IDLE, PH_WAIT, PH_RESP} ph_t;

  cmd_t          mq[$];
  logic [MW-1:0] seen_a[$];
  logic          seen_w[$];
  int            en_count = 0;

  // Transaction model: queue of commands, one read in flight.
  initial begin : cmp
    logic          seen_rst;
    ph_t           ph;
    int            wcnt;
    logic          drop;
    logic          old_drop;
    logic [DW-1:0] m_rd;
    logic          m_err;
    logic          acc;
    logic          e_rdy;
    logic          e_err;
    logic [DW-1:0] e_rd;
    logic          e_en;
    logic          do_push;
    cmd_t          c;
    seen_rst = 1'b0;
    ph = PH_IDLE;
    wcnt = 0;
    drop = 1'b0;
    m_rd = '0;
    m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen_rst = 1'b1;
        mq.delete();
        ph = PH_IDLE;
        drop = 1'b0;
        m_rd = '0;
        m_err = 1'b0;
        check("rst_outputs", 64'(|{pready, pslverr, prdata,
              mig_en, mig_w_en, mig_addr, mig_wdata, mig_strb}), 0);
      end else if (seen_rst) begin
        acc = psel && penable;
        e_rdy = 1'b0;
        e_err = 1'b0;
        e_rd = '0;
        e_en = (mq.size() > 0) && mig_ready;
        old_drop = drop;
        do_push = 1'b0;
        case (ph)
          PH_IDLE: begin
            if (acc) begin
              if (paddr[1:0] != 2'b00) begin
                e_rdy = 1'b1;
                e_err = 1'b1;
              end else if (pwrite) begin
                if (mq.size() < DEPTH) begin
                  do_push = 1'b1;
                  e_rdy = 1'b1;
                end
              end else if (mq.size() < DEPTH && !old_drop) begin
                do_push = 1'b1;
                ph = PH_WAIT;
                wcnt = 0;
              end
            end
          end
          PH_WAIT: begin
            wcnt++;
            if (mig_valid) begin
              m_rd = mig_rdata;
              m_err = 1'b0;
              ph = PH_RESP;
            end
`ifdef APB_MIG_TIMEOUT_EN
            else if (wcnt == TO) begin
              m_rd = '0;
              m_err = 1'b1;
              drop = 1'b1;
              ph = PH_RESP;
            end
`endif
          end
          default: begin
            e_rdy = 1'b1;
            e_rd = m_rd;
            e_err = m_err;
            ph = PH_IDLE;
          end
        endcase
        if (old_drop && mig_valid) drop = 1'b0;
        check("pready", 64'(pready), 64'(e_rdy));
        check("pslverr", 64'(pslverr), 64'(e_err));
        check("prdata", 64'(prdata), 64'(e_rd));
        check("mig_en", 64'(mig_en), 64'(e_en));
        if (e_en && mig_en) begin
          check("mig_w_en", 64'(mig_w_en), 64'(mq[0].w));
          check("mig_addr", 64'(mig_addr), 64'(mq[0].a));
          check("mig_strb", 64'(mig_strb), 64'(mq[0].s));
          if (mq[0].w) check("mig_data", 64'(mig_wdata), 64'(mq[0].d));
        end else begin
          check("mig_w_en_idle", 64'(mig_w_en), 0);
        end
        if (mig_en) begin
          en_count++;
          seen_a.push_back(mig_addr);
          seen_w.push_back(mig_w_en);
        end
        if (e_en && mq.size() > 0) void'(mq.pop_front());
        if (do_push) begin
          c.w = pwrite;
          c.a = paddr[MW+1:2];
          c.d = pwdata;
          c.s = pwrite ? pstrb : 4'h0;
          mq.push_back(c);
        end
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] s,
                          output logic [DW-1:0] rd, output logic err,
                          output int ws);
    @(posedge clk); #1;
    psel = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    ws = 0;
    forever begin
      @(negedge clk);
      if (pready) break;
      ws++;
      if (ws > 200) begin
        check("apb_wait_bound", 64'(ws), 0);
        break;
      end
    end
    rd = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0;
    penable = 1'b0;
  endtask

  task automatic mig_respond(input logic [DW-1:0] d, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mig_en && !mig_w_en) && n < 200);
    if (n >= 200) begin
      check("mig_rd_cmd_bound", 64'(n), 0);
    end else begin
      repeat (lat) @(posedge clk);
      #1;
      mig_valid = 1'b1;
      mig_rdata = d;
      @(posedge clk); #1;
      mig_valid = 1'b0;
      mig_rdata = '0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t limit 400000", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [DW-1:0] rd;
    logic          er;
    int            ws;
    int            e0;
    int            base;
    rst_n = 1'b0;
    psel = 1'b1;
    penable = 1'b1;
    pwrite = 1'b0;
    paddr = 32'h102;
    pwdata = '0;
    pstrb = '0;
    mig_ready = 1'b1;
    mig_valid = 1'b0;
    mig_rdata = '0;

    repeat (3) begin
      @(negedge clk);
      check("rst_pready", 64'(pready), 0);
      check("rst_pslverr", 64'(pslverr), 0);
      check("rst_mig_en", 64'(mig_en), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    psel = 1'b0;
    penable = 1'b0;
    paddr = '0;
    e0 = en_count;
    repeat (5) @(negedge clk);
    check("post_rst_no_cmd", 64'(en_count - e0), 0);

    @(posedge clk); #1;
    mig_ready = 1'b0;
    base = seen_a.size();
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, 32'((i + 1) * 16), 32'(8'hA0 + 16 * i),
               4'hF, rd, er, ws);
      check("wr_zero_wait", 64'(ws), 0);
      check("wr_no_err", 64'(er), 0);
    end
    fork
      apb_xfer(1'b1, 32'h50, 32'hE0, 4'hF, rd, er, ws);
      begin
        repeat (4) @(posedge clk);
        #1;
        mig_ready = 1'b1;
      end
    join
    check("wr5_stall_cycles", 64'(ws), 3);
    repeat (8) @(negedge clk);
    check("wr_cmd_count", 64'(seen_a.size() - base), 5);
    if (seen_a.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        check("wr_mig_addr_order", 64'(seen_a[base + i]),
              64'((i + 1) * 4));
      end
    end

    base = seen_a.size();
    apb_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd, er, ws);
    check("wr100_zero_wait", 64'(ws), 0);
    fork
      apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, rd, er, ws);
      mig_respond(32'hDEADBEEF, 3);
    join
    check("rd100_data", 64'(rd), 64'h0DEADBEEF);
    check("rd100_err", 64'(er), 0);
    check("rd100_wait_states", 64'(ws), 5);
    check("rd100_cmd_count", 64'(seen_a.size() - base), 2);
    if (seen_a.size() >= base + 2) begin
      check("rd100_first_is_wr", 64'(seen_w[base]), 1);
      check("rd100_then_rd", 64'(seen_w[base + 1]), 0);
      check("rd100_rd_addr", 64'(seen_a[base + 1]), 64'h40);
    end

    e0 = en_count;
    apb_xfer(1'b0, 32'h102, 32'h0, 4'h0, rd, er, ws);
    check("mis_rd_wait", 64'(ws), 0);
    check("mis_rd_err", 64'(er), 1);
    check("mis_rd_data", 64'(rd), 0);
    apb_xfer(1'b1, 32'h106, 32'h55, 4'hF, rd, er, ws);
    check("mis_wr_wait", 64'(ws), 0);
    check("mis_wr_err", 64'(er), 1);
    repeat (3) @(negedge clk);
    check("mis_no_cmd", 64'(en_count - e0), 0);

`ifdef APB_MIG_TIMEOUT_EN
    apb_xfer(1'b0, 32'h200, 32'h0, 4'h0, rd, er, ws);
    check("to_wait_states", 64'(ws), 9);
    check("to_err", 64'(er), 1);
    check("to_data", 64'(rd), 0);
    @(posedge clk); #1;
    mig_valid = 1'b1;
    mig_rdata = 32'h1234;
    @(posedge clk); #1;
    mig_valid = 1'b0;
    mig_rdata = '0;
    fork
      apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, rd, er, ws);
      mig_respond(32'hDEADBEEF, 3);
    join
    check("to_next_data", 64'(rd), 64'h0DEADBEEF);
    check("to_next_err", 64'(er), 0);
    check("to_next_wait", 64'(ws), 5);
`endif

    @(posedge clk); #1;
    mig_ready = 1'b0;
    apb_xfer(1'b1, 32'h300, 32'h11, 4'h3, rd, er, ws);
    apb_xfer(1'b1, 32'h304, 32'h22, 4'hC, rd, er, ws);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mig_ready = 1'b1;
    e0 = en_count;
    repeat (5) @(negedge clk);
    check("midrst_queue_flushed", 64'(en_count - e0), 0);
    apb_xfer(1'b1, 32'h40, 32'h77, 4'hF, rd, er, ws);
    check("midrst_wr_wait", 64'(ws), 0);
    repeat (3) @(negedge clk);
    check("midrst_one_cmd", 64'(en_count - e0), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mig_bridge.md
# apb_mig_bridge

Single-clock APB slave to MIG user-port bridge with parametrised widths, a posted-write command queue, a blocking read path and an optional read timeout. It sits between the APB peripheral fabric and the MIG application interface when both run on the same clock. It replaces the two-FIFO clock-crossing bridge in single-domain builds, adding queue depth, misalignment errors and timeout recovery.

## Interface
- `ADDR_W`, 32, APB address width.
- `DATA_W`, 32, APB and MIG data width; multiple of 8, at least 16.
- `MIG_ADDR_W`, 27, MIG word-address width; `MIG_ADDR_W + $clog2(DATA_W/8) <= ADDR_W`.
- `CMD_DEPTH`, 4, command queue entries; power of two, at least 2.
- `TIMEOUT`, 256, read-wait cycles before error; at least 2. Used only with `APB_MIG_TIMEOUT_EN`.

Ports:
- `pclk_i`  in  1  sole clock.
- `preset_ni`  in  1  reset: synchronous, active-low.
- `psel_i`, `penable_i`, `pwrite_i`  in  1 each  APB control.
- `paddr_i`  in  ADDR_W  byte address.
- `pwdata_i`  in  DATA_W  write data.
- `pstrb_i`  in  DATA_W/8  write byte strobes.
- `pready_o`, `pslverr_o`  out  1 each  APB response.
- `prdata_o`  out  DATA_W  read data.
- `mig_ready_i`  in  1  MIG accepts a command this cycle.
- `mig_en_o`, `mig_w_en_o`  out  1 each  command valid; write command.
- `mig_addr_o`  out  MIG_ADDR_W  word address.
- `mig_data_o`  out  DATA_W  write data.
- `mig_strb_o`  out  DATA_W/8  write strobes; all zero on reads.
- `mig_valid_i`  in  1  read data valid.
- `mig_data_i`  in  DATA_W  read data.

## Operation
- Queue entry: {write, word address, data, strb}. Word address is `paddr_i >> $clog2(DATA_W/8)`, truncated to MIG_ADDR_W.
- Pop: `mig_en_o = !empty && mig_ready_i`; the entry pops in the same cycle. `mig_w_en_o = mig_en_o && head.write`. Address, data and strb always show the queue head.
- FSM states are IDLE, RD_WAIT and RESP. Access phase means `psel_i && penable_i`.
- IDLE, misaligned access (low `paddr_i` bits not zero): `pready_o = 1`, `pslverr_o = 1`, `prdata_o = 0`. Nothing is pushed.
- IDLE, aligned write:
  - Queue not full: push, and `pready_o = 1` in the same cycle (posted write).
  - Queue full: hold `pready_o = 0` until space exists.
- IDLE, aligned read, queue not full and `drop` clear: push, go to RD_WAIT. `pready_o = 0`. If the queue is full or `drop` is set, wait in IDLE.
- RD_WAIT: when `mig_valid_i` is high, capture `mig_data_i` into `rdata_q` and go to RESP.
- RESP: `pready_o = 1`, `prdata_o = rdata_q`, `pslverr_o = err_q`. Return to IDLE.
- Only one read is outstanding. Reads are ordered behind all earlier queued writes (in-order queue).
- `mig_valid_i` outside RD_WAIT, with `drop` clear, is ignored.
- Simultaneous push and pop on a full queue: the push is refused. Occupancy counter width is `$clog2(CMD_DEPTH)+1`, and pointers wrap modulo CMD_DEPTH.
- `pready_o`, `pslverr_o` and `prdata_o` are zero whenever no response is driven.

## Timing
- Reset (`preset_ni` low at a `pclk_i` edge):
  - FSM goes to IDLE; queue empty; `rdata_q`, `err_q`, `drop` and the timeout counter are cleared.
  - All outputs are 0 from the next cycle on, and while reset is held.
  - A reset mid-transfer abandons queued commands and any outstanding read.
- Posted write: zero wait states. The earliest `mig_en_o` is one cycle after the push.
- Read, queue empty, `mig_ready_i` high: push at access cycle N, `mig_en_o` at N+1. If `mig_valid_i` arrives at cycle M, `pready_o` is high at M+1.
- Minimum read latency: 2 wait states plus the MIG latency.

## Configuration
- Macro: `APB_MIG_TIMEOUT_EN`.
- Defined:
  - A counter runs in RD_WAIT, cleared on entry.
  - If `mig_valid_i` has not arrived by the TIMEOUT-th RD_WAIT cycle, set `err_q = 1`, `rdata_q = 0`, set `drop`, and go to RESP.
  - While `drop` is set, the next `mig_valid_i` is discarded and clears `drop`.
  - A `mig_valid_i` arriving in the same cycle as expiry wins: normal data, no error.
- Undefined: no counter and no `drop` logic; RD_WAIT waits indefinitely. `pslverr_o` is asserted only for misalignment.

## Test plan
- Reset held for 3 cycles with `psel_i` high: all outputs 0, and `mig_en_o` stays 0 for 5 cycles after release.
- Five back-to-back writes (0x10..0x50, data 0xA0..0xE0, strb 0xF) with `mig_ready_i = 0`, CMD_DEPTH = 4:
  - The first four complete with zero wait states; the fifth stalls.
  - Raise `mig_ready_i`: MIG sees addresses 0x4..0x14 in order, and the fifth completes the cycle after the first pop.
- Write 0x100 = 0xDEADBEEF, then read 0x100, with MIG returning 0xDEADBEEF 3 cycles after its read command:
  - The read command follows the write on the MIG port.
  - `prdata_o = 0xDEADBEEF` and `pslverr_o = 0`.
- Read of address 0x102: one-cycle response with `pslverr_o = 1` and `prdata_o = 0`; `mig_en_o` never asserts.
- With `APB_MIG_TIMEOUT_EN` and TIMEOUT = 8, MIG never answers:
  - `pready_o` and `pslverr_o` rise after 8 RD_WAIT cycles.
  - A late `mig_valid_i` with data 0x1234 is dropped.
  - The next read returns its own fresh data, not 0x1234.
- Simultaneous push and pop on a full queue: the push stalls one cycle, then is accepted; no entry is lost or duplicated.
